// File: rtl/gear_pkg.sv
// Shared definitions for the gear shift controller: FSM states, gear and
// speed types, per-gear speed windows and automatic shift thresholds.
package gear_pkg;

  typedef enum logic [1:0] {
    NEUTRAL,
    DRIVE,
    CLUTCH,
    HOLD
  } state_t;

  typedef logic [2:0] gear_t;
  typedef logic [6:0] spd_t;

  localparam gear_t GEAR_N    = 3'd0;
  localparam gear_t GEAR_MIN  = 3'd1;
  localparam gear_t GEAR_MAX  = 3'd5;
  localparam spd_t  SPEED_MAX = 7'd99;

  // Tables are indexed by gear code; entries 0, 6 and 7 are unused padding so
  // that any 3-bit code indexes safely.
  //                                     7      6      5      4      3      2      1      0
  localparam logic [7:0][6:0] WIN_LO = {7'd0,  7'd0,  7'd75, 7'd55, 7'd35, 7'd15, 7'd0,  7'd0};
  localparam logic [7:0][6:0] WIN_HI = {7'd0,  7'd0,  7'd99, 7'd85, 7'd65, 7'd45, 7'd25, 7'd0};
  // Upshift at hi-3 (gears 1..4), downshift at lo+3 (gears 2..5).
  localparam logic [7:0][6:0] UP_THR = {7'd0,  7'd0,  7'd0,  7'd82, 7'd62, 7'd42, 7'd22, 7'd0};
  localparam logic [7:0][6:0] DN_THR = {7'd0,  7'd0,  7'd78, 7'd58, 7'd38, 7'd18, 7'd0,  7'd0};

  // Force any gear code into the engaged range 1..5.
  function automatic gear_t clamp_gear(input gear_t g);
    if (g < GEAR_MIN) return GEAR_MIN;
    if (g > GEAR_MAX) return GEAR_MAX;
    return g;
  endfunction

  // True when speed s lies inside the legal window of gear g.
  function automatic logic in_window(input gear_t g, input spd_t s);
    return (s >= WIN_LO[g]) && (s <= WIN_HI[g]);
  endfunction

endpackage

// File: rtl/gear_shift_ctrl_if.sv
// Driver-side signal bundle of the gear shift controller: pedal, ignition,
// speed and manual request inputs plus the gear/status outputs.
interface gear_shift_ctrl_if #(
  parameter int SPD_BITS = 7
);
  logic                key2;
  logic [SPD_BITS-1:0] speed;
  logic                accel;
  logic                brake;
  logic                auto_mode;
  logic [2:0]          man_gear;
  logic                man_req;
  logic [2:0]          gear;
  logic                shift_busy;
  logic                shift_done;
  logic                shift_reject;

  modport master (
    output key2, speed, accel, brake, auto_mode, man_gear, man_req,
    input  gear, shift_busy, shift_done, shift_reject
  );

  modport slave (
    input  key2, speed, accel, brake, auto_mode, man_gear, man_req,
    output gear, shift_busy, shift_done, shift_reject
  );
endinterface

// File: rtl/shift_timer.sv
// Loadable down-counter that stops at zero; used for clutch and dwell timing.
module shift_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Clear beats load; otherwise count down and park at zero.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                count <= '0;
    else if (clear)          count <= '0;
    else if (load)           count <= load_val;
    else if (count != '0)    count <= count - WIDTH'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/gear_shift_ctrl.sv
// Transmission controller: launches from neutral, picks gears 1..5 from speed
// and pedals in automatic mode, validates driver requests in manual mode, and
// sequences every shift through a clutch delay and a post-shift dwell.
module gear_shift_ctrl
  import gear_pkg::*;
#(
  parameter int SPD_BITS  = 7,
  parameter int SHIFT_CYC = 4,
  parameter int DWELL_CYC = 16
) (
  input logic              clk,
  input logic              rst,
  gear_shift_ctrl_if.slave bus
);

  localparam int CW = (SHIFT_CYC > 1) ? $clog2(SHIFT_CYC) : 1;
  localparam int DW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  // Timers are loaded with N-1: the cycle that observes zero is the Nth.
  localparam logic [CW-1:0] CLUTCH_LOAD = CW'(SHIFT_CYC - 1);
  localparam logic [DW-1:0] DWELL_LOAD  = DW'(DWELL_CYC - 1);

  state_t              state;
  gear_t               gear_q;
  gear_t               target;
  logic                busy_q;
  logic                done_q;
  logic                reject_q;

  logic [SPD_BITS-1:0] speed_raw;
  spd_t                spd;
  logic                go;
  gear_t               go_target;
  logic                reject_req;
  logic                clutch_zero;
  logic                dwell_zero;
  logic                dwell_load;
  logic                timers_clear;

  assign speed_raw = bus.speed;

  // Saturate out-of-range speed readings at 99.
  always_comb begin
    if (int'(speed_raw) > int'(SPEED_MAX)) spd = SPEED_MAX;
    else                                   spd = spd_t'(speed_raw);
  end

  // Shift decision and target-gear selection for the current state.
  always_comb begin
    go         = 1'b0;
    go_target  = gear_q;
    reject_req = 1'b0;
    case (state)
      NEUTRAL: begin
        if (bus.accel && !bus.brake && spd <= WIN_HI[GEAR_MIN]) begin
          go        = 1'b1;
          go_target = GEAR_MIN;
        end
      end
      DRIVE: begin
        if (spd == '0 && bus.brake && gear_q > GEAR_MIN) begin
          // Stopped under braking: drop straight back to first.
          go        = 1'b1;
          go_target = GEAR_MIN;
        end else if (bus.auto_mode) begin
          if (gear_q > GEAR_MIN && spd <= DN_THR[gear_q]) begin
            go        = 1'b1;
            go_target = gear_q - 3'd1;
          end else if (gear_q < GEAR_MAX && bus.accel && !bus.brake &&
                       spd >= UP_THR[gear_q]) begin
            go        = 1'b1;
            go_target = gear_q + 3'd1;
          end
        end else if (bus.man_req && bus.man_gear != gear_q) begin
          if (bus.man_gear >= GEAR_MIN && bus.man_gear <= GEAR_MAX &&
              in_window(bus.man_gear, spd)) begin
            go        = 1'b1;
            go_target = bus.man_gear;
          end else begin
            reject_req = 1'b1;
          end
        end
      end
      CLUTCH, HOLD: reject_req = bus.man_req;
      default: ;
    endcase
    if (!bus.key2) begin
      go         = 1'b0;
      reject_req = 1'b0;
    end
  end

  assign timers_clear = !bus.key2;
  assign dwell_load   = (state == CLUTCH) && clutch_zero && bus.key2;

  shift_timer #(.WIDTH(CW)) u_clutch_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (go),
    .clear    (timers_clear),
    .load_val (CLUTCH_LOAD),
    .zero     (clutch_zero)
  );

  shift_timer #(.WIDTH(DW)) u_dwell_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (dwell_load),
    .clear    (timers_clear),
    .load_val (DWELL_LOAD),
    .zero     (dwell_zero)
  );

  // Shift sequencer: NEUTRAL/DRIVE -> CLUTCH -> HOLD -> DRIVE, key-off to NEUTRAL.
  // NOTE: only control/state flops exist here and each one gets a reset value;
  // there is no storage array that would need to be left unreset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= NEUTRAL;
      gear_q   <= GEAR_N;
      target   <= GEAR_N;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      reject_q <= reject_req;
      if (!bus.key2) begin
        state  <= NEUTRAL;
        gear_q <= GEAR_N;
        target <= GEAR_N;
        busy_q <= 1'b0;
      end else begin
        case (state)
          NEUTRAL, DRIVE: begin
            if (go) begin
              state  <= CLUTCH;
              target <= clamp_gear(go_target);
              busy_q <= 1'b1;
            end
          end
          CLUTCH: begin
            if (clutch_zero) begin
              state  <= HOLD;
              gear_q <= target;
              done_q <= 1'b1;
              busy_q <= 1'b0;
            end
          end
          HOLD: begin
            if (dwell_zero) state <= DRIVE;
          end
          default: state <= NEUTRAL;
        endcase
      end
    end
  end

  assign bus.gear         = gear_q;
  assign bus.shift_busy   = busy_q;
  assign bus.shift_done   = done_q;
  assign bus.shift_reject = reject_q;

endmodule

// File: tb/tb_gear_shift_ctrl.sv
// Directed bench for gear_shift_ctrl: launch, automatic upshift chain,
// downshift hysteresis, manual requests, key-off abort, stop downshift and
// asynchronous reset.
module tb_gear_shift_ctrl;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  gear_shift_ctrl_if #(.SPD_BITS(7)) bus ();

  gear_shift_ctrl #(
    .SPD_BITS  (7),
    .SHIFT_CYC (4),
    .DWELL_CYC (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_g1;
    int busy_cnt;
    int done_cnt;
    int up_cnt;
    int up_spd [4];
    logic prev_busy;
    int osc [8];

    errors = 0;
    checks = 0;
    osc = '{39, 40, 41, 44, 42, 39, 43, 39};

    // Reset state
    rst           = 1'b0;
    bus.key2      = 1'b0;
    bus.speed     = '0;
    bus.accel     = 1'b0;
    bus.brake     = 1'b0;
    bus.auto_mode = 1'b1;
    bus.man_gear  = 3'd0;
    bus.man_req   = 1'b0;
    #2;
    check("reset_gear",   32'(bus.gear), 0);
    check("reset_busy",   32'(bus.shift_busy), 0);
    check("reset_done",   32'(bus.shift_done), 0);
    check("reset_reject", 32'(bus.shift_reject), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Key-on launch from rest: 4 busy cycles, gear 1 on the 5th edge
    bus.key2  = 1'b1;
    bus.accel = 1'b1;
    first_g1  = 0;
    busy_cnt  = 0;
    done_cnt  = 0;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (bus.gear == 3'd1 && first_g1 == 0) first_g1 = i;
      busy_cnt += int'(bus.shift_busy);
      done_cnt += int'(bus.shift_done);
    end
    check("launch_latency", 32'(first_g1), 5);
    check("launch_busy",    32'(busy_cnt), 4);
    check("launch_done",    32'(done_cnt), 1);
    check("launch_gear",    32'(bus.gear), 1);

    // Automatic upshift chain: ramp 1..99, two cycles per step
    up_cnt    = 0;
    prev_busy = 1'b0;
    for (int s = 1; s <= 99; s++) begin
      for (int k = 0; k < 2; k++) begin
        bus.speed = 7'(s);
        tick();
        if (bus.shift_busy && !prev_busy) begin
          if (up_cnt < 4) up_spd[up_cnt] = s;
          up_cnt++;
        end
        prev_busy = bus.shift_busy;
      end
    end
    check("up_count", 32'(up_cnt), 4);
    check("up_1to2_speed", 32'(up_spd[0]), 22);
    check("up_2to3_speed", 32'(up_spd[1]), 42);
    check("up_3to4_speed", 32'(up_spd[2]), 62);
    check("up_4to5_speed", 32'(up_spd[3]), 82);
    check("up_final_gear", 32'(bus.gear), 5);

    // Coast down to gear 3 at speed 50
    bus.accel = 1'b0;
    bus.speed = 7'd50;
    ticks(60);
    check("coast_gear3", 32'(bus.gear), 3);

    // Hysteresis: 39..44 holds gear 3, 38 drops to 2
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      bus.speed = 7'(osc[i % 8]);
      tick();
      busy_cnt += int'(bus.shift_busy);
    end
    check("hyst_no_shift", 32'(busy_cnt), 0);
    check("hyst_gear3",    32'(bus.gear), 3);
    bus.speed = 7'd38;
    tick();
    check("hyst_dn_start", 32'(bus.shift_busy), 1);
    ticks(4);
    check("hyst_dn_gear2", 32'(bus.gear), 2);
    ticks(20);

    // Manual 2->3 at speed 40, with a request during CLUTCH and HOLD
    bus.auto_mode = 1'b0;
    bus.speed     = 7'd40;
    bus.man_gear  = 3'd3;
    bus.man_req   = 1'b1;
    tick();
    bus.man_req = 1'b0;
    check("man_go_busy",   32'(bus.shift_busy), 1);
    check("man_go_reject", 32'(bus.shift_reject), 0);
    tick();
    bus.man_gear = 3'd5;
    bus.man_req  = 1'b1;
    tick();
    bus.man_req = 1'b0;
    check("man_clutch_reject", 32'(bus.shift_reject), 1);
    check("man_clutch_busy",   32'(bus.shift_busy), 1);
    ticks(2);
    check("man_gear3", 32'(bus.gear), 3);
    check("man_done",  32'(bus.shift_done), 1);
    bus.man_gear = 3'd2;
    bus.man_req  = 1'b1;
    tick();
    bus.man_req = 1'b0;
    check("man_hold_reject", 32'(bus.shift_reject), 1);
    check("man_hold_gear",   32'(bus.gear), 3);
    ticks(20);

    // Manual request outside the window is refused, gear unchanged
    bus.speed    = 7'd20;
    bus.man_gear = 3'd4;
    bus.man_req  = 1'b1;
    tick();
    bus.man_req = 1'b0;
    check("man_window_reject", 32'(bus.shift_reject), 1);
    check("man_window_busy",   32'(bus.shift_busy), 0);
    tick();
    check("man_reject_pulse",  32'(bus.shift_reject), 0);
    check("man_window_gear",   32'(bus.gear), 3);
    // Same-gear request: silent
    bus.man_gear = 3'd3;
    bus.man_req  = 1'b1;
    tick();
    bus.man_req = 1'b0;
    check("man_same_reject", 32'(bus.shift_reject), 0);
    check("man_same_busy",   32'(bus.shift_busy), 0);
    // Invalid gear code
    bus.speed    = 7'd40;
    bus.man_gear = 3'd7;
    bus.man_req  = 1'b1;
    tick();
    bus.man_req = 1'b0;
    check("man_invalid_reject", 32'(bus.shift_reject), 1);

    // Key off during cycle 2 of the clutch
    bus.man_gear = 3'd2;
    bus.man_req  = 1'b1;
    tick();
    bus.man_req = 1'b0;
    check("keyoff_busy_start", 32'(bus.shift_busy), 1);
    tick();
    bus.key2 = 1'b0;
    tick();
    check("keyoff_gear", 32'(bus.gear), 0);
    check("keyoff_busy", 32'(bus.shift_busy), 0);
    done_cnt = int'(bus.shift_done);
    for (int i = 0; i < 8; i++) begin
      tick();
      done_cnt += int'(bus.shift_done);
    end
    check("keyoff_no_done", 32'(done_cnt), 0);
    check("keyoff_gear_stays", 32'(bus.gear), 0);

    // Relaunch, manual 1->4 at speed 60
    bus.key2      = 1'b1;
    bus.auto_mode = 1'b1;
    bus.accel     = 1'b1;
    bus.speed     = 7'd0;
    ticks(25);
    check("relaunch_gear1", 32'(bus.gear), 1);
    bus.auto_mode = 1'b0;
    bus.accel     = 1'b0;
    bus.speed     = 7'd60;
    bus.man_gear  = 3'd4;
    bus.man_req   = 1'b1;
    tick();
    bus.man_req = 1'b0;
    check("skip_busy", 32'(bus.shift_busy), 1);
    ticks(24);
    check("skip_gear4", 32'(bus.gear), 4);
    bus.auto_mode = 1'b1;
    ticks(3);
    check("auto_g4_steady", 32'(bus.gear), 4);

    // Brake to a stop in gear 4: one shift to gear 1, nothing during HOLD
    bus.brake = 1'b1;
    bus.speed = 7'd0;
    tick();
    check("stop_busy", 32'(bus.shift_busy), 1);
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      busy_cnt += int'(bus.shift_busy);
      done_cnt += int'(bus.shift_done);
    end
    check("stop_busy_cycles", 32'(busy_cnt), 3);
    check("stop_done_count",  32'(done_cnt), 1);
    check("stop_gear1",       32'(bus.gear), 1);

    // Async reset between edges, mid-clutch
    bus.brake     = 1'b0;
    bus.auto_mode = 1'b0;
    bus.speed     = 7'd20;
    bus.man_gear  = 3'd2;
    bus.man_req   = 1'b1;
    tick();
    bus.man_req = 1'b0;
    check("arst_pre_busy", 32'(bus.shift_busy), 1);
    check("arst_pre_gear", 32'(bus.gear), 1);
    #3 rst = 1'b0;
    #1;
    check("arst_gear", 32'(bus.gear), 0);
    check("arst_busy", 32'(bus.shift_busy), 0);
    check("arst_done", 32'(bus.shift_done), 0);
    ticks(2);
    rst = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
